red_pitaya_daisy_rx_deframe: RTL and testbench

RED_PITAYA_DAISY_RX_DEFRAME -- requirements
Module: red_pitaya_daisy_rx_deframe

---
 rtl/red_pitaya_daisy_rx_deframe.sv | 147 ++++++++++++++
 tb/tb_red_pitaya_daisy_rx_deframe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_daisy_rx_deframe.sv
// Daisy-chain receive deframer: aligns a nibble stream on training words and rebuilds 16-bit words.
// Optional macro DAISY_RX_STATS_EN adds par_words_o, a saturating count of words delivered while locked.
module red_pitaya_daisy_rx_deframe #(
  parameter logic [15:0] TRAIN_PAT = 16'h5A3C,
  parameter int unsigned LOCK_CNT  = 4
) (
  input  logic        par_clk_i,
  input  logic        par_rst_i,
  input  logic        sync_mode_i,
  input  logic [3:0]  par_nib_i,
  input  logic        par_relock_i,
  output logic        par_dv_o,
  output logic [15:0] par_dat_o,
  output logic        par_lock_o
`ifdef DAISY_RX_STATS_EN
  ,
  output logic [15:0] par_words_o
`endif
);

  localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic is_train(input logic [15:0] w);
    return (w == TRAIN_PAT);
  endfunction

  state_t      state_r;
  logic [1:0]  ph_r;
  logic [3:0]  mc_r;
  // Only the upper three nibbles of the shift register are ever read back.
  logic [15:4] sr_r;
  logic [15:0] cand_s;
  logic        is_pat_s;
  logic        boundary_s;

  // Candidate word: the current nibble on top of the three most recent ones.
  always_comb begin
    cand_s     = {par_nib_i, sr_r[15:4]};
    is_pat_s   = is_train(cand_s);
    boundary_s = (ph_r == 2'd3);
  end

  // Alignment state machine, shift register and registered outputs.
  always_ff @(posedge par_clk_i or posedge par_rst_i) begin
    if (par_rst_i) begin
      state_r    <= ST_HUNT;
      ph_r       <= 2'd0;
      mc_r       <= 4'd0;
      sr_r       <= 12'h000;
      par_dv_o   <= 1'b0;
      par_dat_o  <= 16'h0000;
      par_lock_o <= 1'b0;
    end else begin
      sr_r <= cand_s[15:4];
      if (sync_mode_i) begin
        state_r    <= ST_HUNT;
        ph_r       <= 2'd0;
        mc_r       <= 4'd0;
        par_dv_o   <= 1'b1;
        par_dat_o  <= {12'h000, par_nib_i};
        par_lock_o <= 1'b0;
      end else if (par_relock_i) begin
        state_r    <= ST_HUNT;
        ph_r       <= 2'd0;
        mc_r       <= 4'd0;
        par_dv_o   <= 1'b0;
        par_lock_o <= 1'b0;
      end else begin
        par_dv_o <= 1'b0;
        case (state_r)
          ST_HUNT: begin
            if (is_pat_s) begin
              ph_r <= 2'd0;
              mc_r <= 4'd1;
              if (LOCK_CNT_C == 4'd1) begin
                state_r    <= ST_LOCKED;
                par_lock_o <= 1'b1;
              end else begin
                state_r <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            ph_r <= ph_r + 2'd1;
            if (boundary_s) begin
              if (is_pat_s) begin
                mc_r <= mc_r + 4'd1;
                if ((mc_r + 4'd1) == LOCK_CNT_C) begin
                  state_r    <= ST_LOCKED;
                  par_lock_o <= 1'b1;
                end
              end else begin
                state_r <= ST_HUNT;
                mc_r    <= 4'd0;
              end
            end
          end
          ST_LOCKED: begin
            ph_r <= ph_r + 2'd1;
            // All-zero words are link idle: latched but not flagged.
            if (boundary_s) begin
              par_dat_o <= cand_s;
              par_dv_o  <= (cand_s != 16'h0000);
            end
          end
          default: begin
            state_r    <= ST_HUNT;
            ph_r       <= 2'd0;
            mc_r       <= 4'd0;
            par_lock_o <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DAISY_RX_STATS_EN
  logic        word_evt_s;
  logic [15:0] words_r;

  // A word is delivered when the locked path raises par_dv_o at a boundary.
  always_comb begin
    word_evt_s = !sync_mode_i && !par_relock_i && (state_r == ST_LOCKED) &&
                 boundary_s && (cand_s != 16'h0000);
  end

  // Saturating delivered-word counter, cleared by reset or realignment.
  always_ff @(posedge par_clk_i or posedge par_rst_i) begin
    if (par_rst_i) begin
      words_r <= 16'h0000;
    end else if (par_relock_i) begin
      words_r <= 16'h0000;
    end else if (word_evt_s && (words_r != 16'hFFFF)) begin
      words_r <= words_r + 16'h0001;
    end
  end

  assign par_words_o = words_r;
`endif

endmodule

// File: tb/tb_red_pitaya_daisy_rx_deframe.sv
// Self-checking bench for red_pitaya_daisy_rx_deframe: directed table, corner sequences and random stream.
`timescale 1ns/1ps
module tb_red_pitaya_daisy_rx_deframe;

  localparam logic [15:0] PAT  = 16'h5A3C;
  localparam int          LCNT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sync_mode = 1'b0;
  logic        relock = 1'b0;
  logic [3:0]  nib = 4'h0;
  logic        dv;
  logic [15:0] dat;
  logic        lock;
`ifdef DAISY_RX_STATS_EN
  logic [15:0] words;
`endif

  always #5 clk = ~clk;

  red_pitaya_daisy_rx_deframe #(.TRAIN_PAT(PAT), .LOCK_CNT(LCNT)) dut (
    .par_clk_i    (clk),
    .par_rst_i    (rst),
    .sync_mode_i  (sync_mode),
    .par_nib_i    (nib),
    .par_relock_i (relock),
    .par_dv_o     (dv),
    .par_dat_o    (dat),
    .par_lock_o   (lock)
`ifdef DAISY_RX_STATS_EN
    ,
    .par_words_o  (words)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  // ---------------- reference model ----------------
  // Alignment is described by the cycle index of the training word that set it:
  // later word boundaries are every 4th cycle from that anchor.
  logic [3:0]  m_hist[$];
  bit          m_aligned, m_locked;
  int          m_good, m_anchor, m_cyc;
  logic        exp_dv, exp_lock;
  logic [15:0] exp_dat, exp_words;

  function automatic void model_reset();
    m_hist = '{4'h0, 4'h0, 4'h0};
    m_aligned = 0; m_locked = 0; m_good = 0; m_anchor = 0; m_cyc = 0;
    exp_dv = 1'b0; exp_lock = 1'b0; exp_dat = 16'h0000; exp_words = 16'h0000;
  endfunction

  function automatic void model_step(input logic [3:0] n, input logic s, input logic r);
    logic [15:0] w;
    bit bnd;
    w   = {n, m_hist[2], m_hist[1], m_hist[0]};
    bnd = ((m_cyc - m_anchor) % 4) == 0;
    if (s) begin
      exp_dv = 1'b1; exp_dat = {12'h000, n}; m_aligned = 0; m_locked = 0;
    end else if (r) begin
      exp_dv = 1'b0; m_aligned = 0; m_locked = 0;
    end else begin
      exp_dv = 1'b0;
      if (!m_aligned) begin
        if (w == PAT) begin
          m_aligned = 1; m_anchor = m_cyc; m_good = 1; m_locked = (LCNT == 1);
        end
      end else if (bnd) begin
        if (m_locked) begin
          exp_dat = w;
          exp_dv  = (w != 16'h0000);
          if (exp_dv && exp_words != 16'hFFFF) exp_words++;
        end else if (w == PAT) begin
          m_good++;
          if (m_good >= LCNT) m_locked = 1;
        end else begin
          m_aligned = 0;
        end
      end
    end
    if (r) exp_words = 16'h0000;
    exp_lock = m_locked;
    m_hist.push_back(n);
    void'(m_hist.pop_front());
    m_cyc++;
  endfunction

  // One clock: drive inputs, advance the model, sample after the edge and compare.
  task automatic cyc(input logic [3:0] n, input logic s, input logic r);
    nib = n; sync_mode = s; relock = r;
    model_step(n, s, r);
    @(posedge clk); #1;
    check("dv", dv, exp_dv);
    check("dat", dat, exp_dat);
    check("lock", lock, exp_lock);
`ifdef DAISY_RX_STATS_EN
    check("words", words, exp_words);
`endif
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int k = 0; k < 4; k++) cyc(w[4*k +: 4], 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; nib = 4'h0; sync_mode = 1'b0; relock = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #3;
    check("rst_dv", dv, 1'b0);
    check("rst_dat", dat, 16'h0000);
    check("rst_lock", lock, 1'b0);
`ifdef DAISY_RX_STATS_EN
    check("rst_words", words, 16'h0000);
`endif
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  nib;
    logic        sync;
    logic        relock;
    logic        edv;
    logic [15:0] edat;
    logic        elock;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [3:0] n, input logic s, input logic r,
                              input logic edv, input logic [15:0] edat, input logic elock);
    vec_t v;
    v.nib = n; v.sync = s; v.relock = r; v.edv = edv; v.edat = edat; v.elock = elock;
    tbl.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] stream[$];
    logic [15:0] rw;
    logic [15:0] pat_v, beef_v, d1234_v;
    int sync_left;
    bit seen_dv;
    logic [3:0] locks_exp[4];

    pat_v = PAT; beef_v = 16'hBEEF; d1234_v = 16'h1234;

    // Lock on four training words, deliver data, idle, training-as-data,
    // relock on a BEEF boundary, then sync pass-through and its exit.
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 4; k++)
        add(pat_v[4*k +: 4], 1'b0, 1'b0, 1'b0, 16'h0000, (w == 3 && k == 3));
    for (int k = 0; k < 4; k++)
      add(d1234_v[4*k +: 4], 1'b0, 1'b0, (k == 3), (k == 3) ? 16'h1234 : 16'h0000, 1'b1);
    for (int k = 0; k < 4; k++)
      add(4'h0, 1'b0, 1'b0, 1'b0, (k == 3) ? 16'h0000 : 16'h1234, 1'b1);
    for (int k = 0; k < 4; k++)
      add(pat_v[4*k +: 4], 1'b0, 1'b0, (k == 3), (k == 3) ? 16'h5A3C : 16'h0000, 1'b1);
    for (int k = 0; k < 4; k++)
      add(beef_v[4*k +: 4], 1'b0, (k == 3), 1'b0, 16'h5A3C, (k != 3));
    add(4'h7, 1'b1, 1'b0, 1'b1, 16'h0007, 1'b0);
    add(4'h8, 1'b1, 1'b0, 1'b1, 16'h0008, 1'b0);
    add(4'h9, 1'b1, 1'b0, 1'b1, 16'h0009, 1'b0);
    add(4'h0, 1'b0, 1'b0, 1'b0, 16'h0009, 1'b0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].nib, tbl[i].sync, tbl[i].relock);
      check($sformatf("tbl%0d_dv", i), dv, tbl[i].edv);
      check($sformatf("tbl%0d_dat", i), dat, tbl[i].edat);
      check($sformatf("tbl%0d_lock", i), lock, tbl[i].elock);
    end

    // Misaligned training after a relock: the garbage nibble must drop CHECK back to HUNT.
    do_reset();
    for (int w = 0; w < 4; w++) send_word(PAT);
    check("seq_locked", lock, 1'b1);
    cyc(4'h0, 1'b0, 1'b1);
    check("seq_relock_drop", lock, 1'b0);
    seen_dv = 0;
    cyc(4'h1, 1'b0, 1'b0);
    seen_dv |= dv;
    for (int w = 0; w < 2; w++) begin
      send_word(PAT);
      seen_dv |= dv;
      check("seq_pre_garbage_lock", lock, 1'b0);
    end
    cyc(4'h7, 1'b0, 1'b0);
    seen_dv |= dv;
    locks_exp = '{4'd0, 4'd0, 4'd0, 4'd1};
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 4; k++) begin
        cyc(pat_v[4*k +: 4], 1'b0, 1'b0);
        seen_dv |= dv;
      end
      check($sformatf("seq_realign_lock_w%0d", w), {31'd0, lock}, {28'd0, locks_exp[w]});
    end
    check("seq_no_dv_before_lock", seen_dv, 1'b0);
    send_word(16'h1234);
    check("seq_data_dv", dv, 1'b1);
    check("seq_data_dat", dat, 16'h1234);

    // Reset in the middle of a data word while locked.
    cyc(4'h4, 1'b0, 1'b0);
    cyc(4'h3, 1'b0, 1'b0);
    #3 rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_dv", dv, 1'b0);
    check("async_rst_dat", dat, 16'h0000);
    check("async_rst_lock", lock, 1'b0);
`ifdef DAISY_RX_STATS_EN
    check("async_rst_words", words, 16'h0000);
`endif
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    seen_dv = 0;
    cyc(4'h2, 1'b0, 1'b0); seen_dv |= dv;
    cyc(4'h1, 1'b0, 1'b0); seen_dv |= dv;
    for (int k = 0; k < 6; k++) begin
      cyc(4'h0, 1'b0, 1'b0);
      seen_dv |= dv;
    end
    check("no_dv_after_rst", seen_dv, 1'b0);

    // Random mix of training words, data, idle, slips, relocks and sync bursts.
    do_reset();
    sync_left = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic s, rl;
      if (stream.size() == 0) begin
        r = $urandom_range(0, 99);
        if (r < 55) rw = PAT;
        else if (r < 75) rw = 16'($urandom);
        else if (r < 85) rw = 16'h0000;
        else rw = 16'hFFFF;
        if (r >= 85) stream.push_back(4'($urandom_range(0, 15)));
        else for (int k = 0; k < 4; k++) stream.push_back(rw[4*k +: 4]);
      end
      if (sync_left > 0) begin
        s = 1'b1; sync_left--;
      end else begin
        s = 1'b0;
        if ($urandom_range(0, 199) == 0) sync_left = $urandom_range(1, 5);
      end
      rl = ($urandom_range(0, 249) == 0);
      cyc(stream.pop_front(), s, rl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
